alu_reservation_station: RTL
============================

# alu_reservation_station

Holds decoded ALU instructions between the decoder and the ALU until both source operands are available, snooping the common data bus (CDB) for missing operands. Issues one ready instruction per cycle to the ALU, tagged with its destination ROB slot. The ALU result returns on the CDB, where the reorder buffer marks the slot ready. Asserts `rsFull` back to the decoder to stall dispatch.

## Interface
- `RS_SIZE`, 4: number of entries, 2..16.
- `dataWidth`, 32: operand/result width.
- `tagWidth`, 4: ROB tag width; `tagFree` (all ones) means "no dependency".
- `opWidth`, 6: ALU opcode width.

Ports (reset `rst`, synchronous, active-high; clock `clk`):
- `clk`  in  1  clock.
- `rst`  in  1  synchronous active-high reset.
- `insertEnable`  in  1  decoder dispatches one instruction this cycle.
- `insertOp`  in  opWidth  ALU opcode.
- `insertDest`  in  tagWidth  destination ROB slot.
- `insertTag1` / `insertTag2`  in  tagWidth  producer tag of each source; `tagFree` if ready.
- `insertData1` / `insertData2`  in  dataWidth  operand value, valid when the tag is `tagFree`.
- `rsFull`  out  1  no free entry; decoder must not assert `insertEnable`.
- `rsCount`  out  $clog2(RS_SIZE)+1  occupied entries.
- `CDB_valid`  in  1  broadcast valid.
- `CDB_tag`  in  tagWidth  broadcasting ROB slot.
- `CDB_data`  in  dataWidth  broadcast value.
- `aluValid`  out  1  issue slot holds a ready instruction.
- `aluReady`  in  1  ALU accepts this cycle.
- `aluOp`, `aluA`, `aluB`, `aluDest`  out  op/data/data/tag  issued instruction.
- `flush`  in  1  mispredict/exception; discard all entries.

## Operation
- Entry fields: busy, op, dest, tag1, data1, tag2, data2. An operand is ready when its tag equals `tagFree`. The entry is ready when busy and both operands are ready.
- **Insert:** writes the lowest-index non-busy entry. If `CDB_valid` and `CDB_tag` equals an incoming source tag in the same cycle, the CDB data is captured and that tag is stored as `tagFree`.
- **Wakeup:** every busy entry compares each non-free tag with `CDB_tag` when `CDB_valid` is high. On a match it latches `CDB_data` and sets the tag to `tagFree`. Both operands may wake on the same broadcast.
- **Select:** the lowest-index ready entry drives `alu*` combinationally, and `aluValid` is high. If `aluValid` and `aluReady` are both high, that entry's busy bit clears at the clock edge.
- **Flush:** clears all busy bits at the edge. A same-cycle insert and issue are both discarded. `flush` has priority over everything except `rst`.
- `rsFull` and `rsCount` are derived from registered busy bits only. An issue in the same cycle does not free a slot for an insert in that cycle.
- `rsCount` is updated as +insert −issue. A simultaneous insert and issue leaves it unchanged.
- Inserting while `rsFull` is a protocol violation: the insert is ignored and no entry is overwritten.

## Timing
- **Reset:** all busy bits are 0, `rsFull`=0, `rsCount`=0, `aluValid`=0. Entry payloads are don't-care.
- **Insert with ready operands:** eligible for issue the cycle after insert (latency 1). There is no same-cycle bypass to the ALU.
- **CDB wakeup:** the woken entry may issue the cycle after the broadcast.
- **Holding:** the `alu*` outputs stay stable while `aluValid`=1 and `aluReady`=0, unless a lower-index entry becomes ready. In that case the selection may change, because selection is not sticky.
- **Reset or flush mid-operation:** takes effect at the next edge. `aluValid` is 0 from the following cycle.

## Structure
- Shared package/defines: `dataWidth`, `tagWidth`, `opWidth`, `tagFree`, and the ALU opcode constants. These are the same definitions the ROB and decoder use.
- One natural sub-module, `rs_priority_select`: lowest-index one-hot pick over RS_SIZE request bits. It is used for both free-slot allocation and ready-entry selection.

## Test plan
1. Reset, then insert op=ADD with tags `tagFree`, data 5 and 7, dest=3 → next cycle `aluValid`=1, `aluA`=5, `aluB`=7, `aluDest`=3. With `aluReady`=1, `rsCount` is 0 after the edge.
2. Insert with tag1=2. Later broadcast CDB tag 2, data 0x1234 → `aluValid` rises the cycle after the broadcast, `aluA`=0x1234.
3. Insert with tag1=4 while CDB broadcasts tag 4, data 9 in the same cycle → the entry issues next cycle with `aluA`=9. No hang.
4. Fill 4 entries with unready operands → `rsFull`=1 and `rsCount`=4. An insert attempt leaves the contents unchanged. Waking entry 2 issues entry 2 first, then `rsFull` drops.
5. Two entries ready with `aluReady`=0 for 3 cycles → outputs stay on entry 0. Then `aluReady`=1 for 2 cycles issues entry 0, then entry 1.
6. Apply `flush` with 3 entries busy and a simultaneous insert → next cycle `rsCount`=0, `aluValid`=0, `rsFull`=0.

Source files
------------

// File: rtl/alu_reservation_station_pkg.sv
// Shared definitions for the ALU reservation station, also used by the ROB
// and the decoder.
//   DATA_WIDTH / TAG_WIDTH / OP_WIDTH : default operand, ROB tag and opcode widths
//   TAG_FREE                          : tag value meaning "operand already available"
//   alu_op_e                          : ALU opcode encodings
package alu_reservation_station_pkg;

   localparam int DATA_WIDTH = 32;
   localparam int TAG_WIDTH  = 4;
   localparam int OP_WIDTH   = 6;

   localparam logic [TAG_WIDTH-1:0] TAG_FREE = '1;

   typedef enum logic [OP_WIDTH-1:0] {
      ALU_ADD  = 6'h00,
      ALU_SUB  = 6'h01,
      ALU_AND  = 6'h02,
      ALU_OR   = 6'h03,
      ALU_XOR  = 6'h04,
      ALU_SLL  = 6'h05,
      ALU_SRL  = 6'h06,
      ALU_SRA  = 6'h07,
      ALU_SLT  = 6'h08,
      ALU_SLTU = 6'h09
   } alu_op_e;

endpackage

// File: rtl/alu_reservation_station_select.sv
// rs_priority_select: lowest-index one-hot pick over N request bits.
// Used for both free-slot allocation and ready-entry selection.
//   req   : request vector
//   grant : one-hot of the lowest set request bit (all zero if none)
//   idx   : binary index of the granted bit (0 if none)
//   any   : at least one request bit is set
module rs_priority_select #(
   parameter int N = 4
) (
   input  logic [N-1:0]         req,
   output logic [N-1:0]         grant,
   output logic [$clog2(N)-1:0] idx,
   output logic                 any
);

   always_comb begin
      grant = '0;
      idx   = '0;
      any   = 1'b0;
      // Walk from the top down so the lowest set bit is the last writer.
      for (int i = N - 1; i >= 0; i--) begin
         if (req[i]) begin
            grant    = '0;
            grant[i] = 1'b1;
            idx      = ($clog2(N))'(i);
            any      = 1'b1;
         end
      end
   end

endmodule

// File: rtl/alu_reservation_station.sv
// ALU reservation station: holds dispatched ALU instructions until both
// operands are available (snooping the CDB), then issues the lowest-index
// ready entry to the ALU.
//   clk, rst (sync, active-high), flush        : clock / reset / discard all
//   insertEnable, insertOp/Dest/Tag1/Tag2/Data1/Data2 : dispatch from decoder
//   rsFull, rsCount                            : occupancy back to decoder
//   CDB_valid, CDB_tag, CDB_data               : result broadcast snooping
//   aluValid, aluReady, aluOp/A/B/Dest         : issue handshake to the ALU
module alu_reservation_station
   import alu_reservation_station_pkg::*;
#(
   parameter int RS_SIZE   = 4,
   parameter int dataWidth = DATA_WIDTH,
   parameter int tagWidth  = TAG_WIDTH,
   parameter int opWidth   = OP_WIDTH
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         insertEnable,
   input  logic [opWidth-1:0]           insertOp,
   input  logic [tagWidth-1:0]          insertDest,
   input  logic [tagWidth-1:0]          insertTag1,
   input  logic [tagWidth-1:0]          insertTag2,
   input  logic [dataWidth-1:0]         insertData1,
   input  logic [dataWidth-1:0]         insertData2,
   output logic                         rsFull,
   output logic [$clog2(RS_SIZE):0]     rsCount,
   input  logic                         CDB_valid,
   input  logic [tagWidth-1:0]          CDB_tag,
   input  logic [dataWidth-1:0]         CDB_data,
   output logic                         aluValid,
   input  logic                         aluReady,
   output logic [opWidth-1:0]           aluOp,
   output logic [dataWidth-1:0]         aluA,
   output logic [dataWidth-1:0]         aluB,
   output logic [tagWidth-1:0]          aluDest,
   input  logic                         flush
);

   localparam int IW = $clog2(RS_SIZE);
   localparam int CW = $clog2(RS_SIZE) + 1;
   localparam logic [tagWidth-1:0] tagFree = '1;

   logic [RS_SIZE-1:0]   busy_q;
   logic [opWidth-1:0]   op_q    [RS_SIZE];
   logic [tagWidth-1:0]  dest_q  [RS_SIZE];
   logic [tagWidth-1:0]  tag1_q  [RS_SIZE];
   logic [tagWidth-1:0]  tag2_q  [RS_SIZE];
   logic [dataWidth-1:0] data1_q [RS_SIZE];
   logic [dataWidth-1:0] data2_q [RS_SIZE];

   logic [RS_SIZE-1:0] ready;
   logic [RS_SIZE-1:0] sel_oh;
   logic [IW-1:0]      sel_idx;
   logic               sel_any;
   logic [RS_SIZE-1:0] free_oh;
   logic [IW-1:0]      free_idx;
   logic               free_any;
   logic               insert_ok;
   logic               issue;
   logic               ins_hit1;
   logic               ins_hit2;
   logic [CW-1:0]      count;

   always_comb begin
      ready = '0;
      for (int i = 0; i < RS_SIZE; i++) begin
         ready[i] = busy_q[i] && (tag1_q[i] == tagFree) && (tag2_q[i] == tagFree);
      end
   end

   rs_priority_select #(.N(RS_SIZE)) u_sel_ready (
      .req   (ready),
      .grant (sel_oh),
      .idx   (sel_idx),
      .any   (sel_any)
   );

   rs_priority_select #(.N(RS_SIZE)) u_sel_free (
      .req   (~busy_q),
      .grant (free_oh),
      .idx   (free_idx),
      .any   (free_any)
   );

   // Occupancy comes from the registered busy bits only, so an issue this
   // cycle never makes room for an insert in the same cycle.
   assign rsFull    = ~free_any;
   assign insert_ok = insertEnable && free_any;
   assign issue     = sel_any && aluReady;

   always_comb begin
      count = '0;
      for (int i = 0; i < RS_SIZE; i++) begin
         count = count + CW'(busy_q[i]);
      end
   end
   assign rsCount = count;

   assign aluValid = sel_any;
   assign aluOp    = op_q[sel_idx];
   assign aluA     = data1_q[sel_idx];
   assign aluB     = data2_q[sel_idx];
   assign aluDest  = dest_q[sel_idx];

   // A producer broadcasting in the dispatch cycle would otherwise be missed.
   assign ins_hit1 = CDB_valid && (insertTag1 != tagFree) && (insertTag1 == CDB_tag);
   assign ins_hit2 = CDB_valid && (insertTag2 != tagFree) && (insertTag2 == CDB_tag);

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         busy_q <= '0;
      end else begin
         for (int i = 0; i < RS_SIZE; i++) begin
            if (insert_ok && free_oh[i]) begin
               busy_q[i] <= 1'b1;
            end else if (issue && sel_oh[i]) begin
               busy_q[i] <= 1'b0;
            end
         end
      end
   end

   // Payloads carry no reset; they are only meaningful while busy.
   always_ff @(posedge clk) begin
      for (int i = 0; i < RS_SIZE; i++) begin
         if (insert_ok && free_oh[i]) begin
            op_q[i]    <= insertOp;
            dest_q[i]  <= insertDest;
            tag1_q[i]  <= ins_hit1 ? tagFree  : insertTag1;
            data1_q[i] <= ins_hit1 ? CDB_data : insertData1;
            tag2_q[i]  <= ins_hit2 ? tagFree  : insertTag2;
            data2_q[i] <= ins_hit2 ? CDB_data : insertData2;
         end else if (busy_q[i] && CDB_valid) begin
            if ((tag1_q[i] != tagFree) && (tag1_q[i] == CDB_tag)) begin
               tag1_q[i]  <= tagFree;
               data1_q[i] <= CDB_data;
            end
            if ((tag2_q[i] != tagFree) && (tag2_q[i] == CDB_tag)) begin
               tag2_q[i]  <= tagFree;
               data2_q[i] <= CDB_data;
            end
         end
      end
   end

   logic unused_free_idx;
   assign unused_free_idx = ^free_idx;

endmodule
